noc_port_requester: RTL and testbench

Input-port requester for the NoC router: the counterpart of the per-port arbiter. It buffers flits arriving from the upstream link, raises the request line toward the arbiter, and presents the flit ID and timeout length that load the arbiter's per-port timer. When granted, it streams the buffered packet to the crossbar. If the grant is withdrawn mid-packet (arbiter timeout), it re-requests and resumes where it stopped.

---
 rtl/noc_port_requester.sv | 211 +++++++++++++++++++++
 tb/tb_noc_port_requester.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_port_requester.sv
// noc_port_requester
// Input-port requester for the NoC router. Buffers flits from the upstream
// link in a DEPTH-entry FIFO, requests the per-port arbiter once a header
// reaches the FIFO head, and streams the packet to the crossbar while
// granted. If the grant is withdrawn mid-packet it drops back to requesting
// and resumes from the next buffered flit.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream flit handshake (in_ready = FIFO not full)
//   in_flit_id, in_data      incoming flit; header data[11:0] = timeout length
//   req, flit_id, length     registered request and timer load values
//   grant                    this port's bit of the arbiter's registered state
//   out_valid, out_flit_id,
//   out_data                 registered flit toward the crossbar
//   pkt_count, drop_count    saturating statistics counters
//
// Configuration:
//   NOC_PORT_REQ_STATS_EN    when defined, pkt_count/drop_count count completed
//                            packets and dropped orphan flits; otherwise both
//                            ports are tied to zero.

module noc_port_requester #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_flit_id,
    input  logic [DATA_W-1:0] in_data,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    input  logic              grant,
    output logic              out_valid,
    output logic [2:0]        out_flit_id,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       pkt_count,
    output logic [15:0]       drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [2:0] ID_HEAD = 3'b001;
    localparam logic [2:0] ID_BODY = 3'b010;
    localparam logic [2:0] ID_TAIL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SEND
    } state_t;

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [DATA_W+2:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [2:0]        head_id;
    logic [DATA_W-1:0] head_data;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign {head_id, head_data} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_flit_id, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request / send FSM
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_d;
    logic              req_d;
    logic [2:0]        flit_id_d;
    logic [11:0]       length_d;
    logic              out_valid_d;
    logic [2:0]        out_flit_id_d;
    logic [DATA_W-1:0] out_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            req         <= 1'b0;
            flit_id     <= '0;
            length      <= '0;
            out_valid   <= 1'b0;
            out_flit_id <= '0;
            out_data    <= '0;
        end else begin
            state       <= state_d;
            req         <= req_d;
            flit_id     <= flit_id_d;
            length      <= length_d;
            out_valid   <= out_valid_d;
            out_flit_id <= out_flit_id_d;
            out_data    <= out_data_d;
        end
    end

    always_comb begin
        state_d       = state;
        req_d         = req;
        flit_id_d     = flit_id;
        length_d      = length;
        out_valid_d   = 1'b0;
        out_flit_id_d = out_flit_id;
        out_data_d    = out_data;
        pop           = 1'b0;

        case (state)
            S_IDLE: begin
                if (!empty) begin
                    if (head_id == ID_HEAD) begin
                        state_d   = S_REQ;
                        req_d     = 1'b1;
                        flit_id_d = ID_HEAD;
                        length_d  = head_data[11:0];
                    end else begin
                        // Orphan flit with no preceding header: discard.
                        pop = 1'b1;
                    end
                end
            end

            S_REQ, S_SEND: begin
                if (grant && !empty) begin
                    pop           = 1'b1;
                    out_valid_d   = 1'b1;
                    out_flit_id_d = head_id;
                    out_data_d    = head_data;
                    // A tail can also be the first flit popped after a resume,
                    // so packet completion is handled the same in both states.
                    if (head_id == ID_TAIL) begin
                        state_d   = S_IDLE;
                        req_d     = 1'b0;
                        flit_id_d = '0;
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (!grant && state == S_SEND) begin
                    // Grant lost mid-packet: re-request, telling the arbiter
                    // timer which flit we resume with.
                    state_d   = S_REQ;
                    flit_id_d = empty ? ID_BODY : head_id;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef NOC_PORT_REQ_STATS_EN
    logic pkt_inc;
    logic drop_inc;

    assign drop_inc = pop && (state == S_IDLE);
    assign pkt_inc  = pop && (state != S_IDLE) && (head_id == ID_TAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (pkt_inc && pkt_count != '1) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (drop_inc && drop_count != '1) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`else
    assign pkt_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_noc_port_requester.sv
`timescale 1ns/1ps
// Self-checking bench for noc_port_requester: directed scenarios plus a
// randomized packet stream, compared every cycle against a queue-based model.

module tb_noc_port_requester;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam logic [2:0]  H = 3'b001;
    localparam logic [2:0]  B = 3'b010;
    localparam logic [2:0]  T = 3'b100;

`ifdef NOC_PORT_REQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_flit_id = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              req;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic              grant = 1'b0;
    logic              out_valid;
    logic [2:0]        out_flit_id;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       pkt_count;
    logic [15:0]       drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_cnt  = 0;

    always #5 clk = ~clk;

    noc_port_requester #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_flit_id (in_flit_id),
        .in_data    (in_data),
        .req        (req),
        .flit_id    (flit_id),
        .length     (length),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_flit_id(out_flit_id),
        .out_data   (out_data),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of buffered flits plus "packet open" and
    // "currently streaming" flags.
    // ------------------------------------------------------------------
    logic [DATA_W+2:0] mq[$];
    logic              m_req;
    logic [2:0]        m_fid;
    logic [11:0]       m_len;
    logic              m_ov;
    logic [2:0]        m_ofid;
    logic [DATA_W-1:0] m_odata;
    int                m_pkt;
    int                m_drop;
    bit                m_open;
    bit                m_streaming;

    always @(posedge clk) begin
        logic [DATA_W+2:0] f;
        bit do_push;
        if (rst) begin
            mq.delete();
            m_req = 0; m_fid = '0; m_len = '0;
            m_ov = 0; m_ofid = '0; m_odata = '0;
            m_pkt = 0; m_drop = 0;
            m_open = 0; m_streaming = 0;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            m_ov = 0;
            if (!m_open) begin
                if (mq.size() > 0) begin
                    if (mq[0][DATA_W+2:DATA_W] == H) begin
                        m_open = 1;
                        m_req  = 1;
                        m_fid  = H;
                        m_len  = mq[0][11:0];
                    end else begin
                        void'(mq.pop_front());
                        if (m_drop < 65535) m_drop++;
                    end
                end
            end else if (grant) begin
                if (mq.size() > 0) begin
                    f = mq.pop_front();
                    m_ov    = 1;
                    m_ofid  = f[DATA_W+2:DATA_W];
                    m_odata = f[DATA_W-1:0];
                    if (m_ofid == T) begin
                        m_open = 0; m_streaming = 0;
                        m_req = 0;  m_fid = '0;
                        if (m_pkt < 65535) m_pkt++;
                    end else begin
                        m_streaming = 1;
                    end
                end
            end else if (m_streaming) begin
                m_streaming = 0;
                m_fid = (mq.size() > 0) ? mq[0][DATA_W+2:DATA_W] : B;
            end
            if (do_push) mq.push_back({in_flit_id, in_data});
        end
    end

    // Every-cycle comparison against the model.
    always begin
        @(posedge clk);
        #1;
        chk("req", req, m_req);
        chk("flit_id", flit_id, m_fid);
        chk("length", length, m_len);
        chk("out_valid", out_valid, m_ov);
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("pkt_count", pkt_count, STATS ? m_pkt : 0);
        chk("drop_count", drop_count, STATS ? m_drop : 0);
        if (m_ov) begin
            chk("out_flit_id", out_flit_id, m_ofid);
            chk("out_data", out_data, m_odata);
        end
        if (out_valid) ov_cnt++;
    end

    // ------------------------------------------------------------------
    // Driver helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; grant = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic push_flit(input logic [2:0] id, input logic [DATA_W-1:0] d);
        int guard;
        guard = 0;
        in_valid = 1; in_flit_id = id; in_data = d;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) timeout_fail("push_wait");
        tick();
        in_valid = 0;
    endtask

    task automatic wait_req_low(input int limit);
        int guard;
        guard = 0;
        while (req && guard < limit) begin
            tick();
            guard++;
        end
        if (req) timeout_fail("req_drop_wait");
    endtask

    logic [DATA_W+2:0] stream[$];

    initial begin
        int base;
        int idx;
        bit acc;
        logic [2:0] oid [5];
        oid[0] = B; oid[1] = T; oid[2] = 3'b101; oid[3] = 3'b000; oid[4] = 3'b110;

        // Test 1: reset values, then a 4-flit packet, grant 3 cycles after req
        do_reset();
        chk("rst_req", req, 0);
        chk("rst_flit_id", flit_id, 0);
        chk("rst_length", length, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flit_id", out_flit_id, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_in_ready", in_ready, 1);
        push_flit(H, 32'hABCD_0014);
        push_flit(B, 32'h1111_1111);
        push_flit(B, 32'h2222_2222);
        push_flit(T, 32'h3333_3333);
        chk("t1_req", req, 1);
        chk("t1_flit_id", flit_id, H);
        chk("t1_length", length, 20);
        tick(); tick(); tick();
        grant = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_out_valid_run", out_valid, 1);
        end
        chk("t1_last_id", out_flit_id, T);
        chk("t1_last_data", out_data, 32'h3333_3333);
        chk("t1_req_drop", req, 0);
        tick();
        chk("t1_out_valid_end", out_valid, 0);
        chk("t1_pkt_count", pkt_count, STATS ? 1 : 0);
        grant = 0;

        // Test 2: orphan flits while IDLE are dropped
        do_reset();
        push_flit(B, 32'h0000_0055);
        push_flit(T, 32'h0000_0066);
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_low", req, 0);
            tick();
        end
        chk("t2_drop_count", drop_count, STATS ? 2 : 0);
        chk("t2_pkt_count", pkt_count, 0);

        // Test 3: grant withdrawn after 2 flits, restored 4 cycles later
        do_reset();
        push_flit(H, 32'h0000_0100);
        for (int i = 1; i < 5; i++) push_flit(B, DATA_W'(i));
        push_flit(T, 32'd5);
        grant = 1;
        tick(); tick();
        chk("t3_second_id", out_flit_id, B);
        chk("t3_second_data", out_data, 1);
        grant = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_gap_out_valid", out_valid, 0);
            chk("t3_gap_req", req, 1);
            chk("t3_gap_flit_id", flit_id, B);
            chk("t3_gap_length", length, 12'h100);
        end
        grant = 1;
        for (int i = 2; i < 6; i++) begin
            tick();
            chk("t3_resume_valid", out_valid, 1);
            chk("t3_resume_data", out_data, i);
        end
        chk("t3_req_drop", req, 0);
        grant = 0;

        // Test 4: 10-flit packet fills the FIFO before grant
        do_reset();
        push_flit(H, 32'h0000_0020);
        for (int i = 1; i < 8; i++) push_flit(B, DATA_W'(i));
        chk("t4_full", in_ready, 0);
        base = ov_cnt;
        in_valid = 1; in_flit_id = B; in_data = 32'd8;
        grant = 1;
        tick();
        chk("t4_ready_back", in_ready, 1);
        push_flit(B, 32'd8);
        push_flit(T, 32'd9);
        wait_req_low(40);
        tick();
        chk("t4_delivered", ov_cnt - base, 10);
        grant = 0;

        // Test 5: reset in the middle of a packet, then a fresh packet
        do_reset();
        push_flit(H, 32'h0000_0033);
        push_flit(B, 32'hA);
        push_flit(B, 32'hB);
        push_flit(B, 32'hC);
        push_flit(T, 32'hD);
        grant = 1;
        tick(); tick();
        rst = 1;
        tick();
        chk("t5_req", req, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_flit_id", flit_id, 0);
        chk("t5_in_ready", in_ready, 1);
        rst = 0; grant = 0;
        tick(); tick();
        chk("t5_empty_req", req, 0);
        chk("t5_no_drops", drop_count, 0);
        push_flit(H, 32'h0000_0007);
        push_flit(T, 32'hE);
        chk("t5_new_length", length, 7);
        grant = 1;
        tick(); tick();
        chk("t5_new_tail", out_flit_id, T);
        chk("t5_new_req", req, 0);
        grant = 0;

        // Randomized packet stream with random valid/grant and one reset
        do_reset();
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 4) == 0) begin
                stream.push_back({oid[$urandom_range(0, 4)], DATA_W'($urandom())});
            end else begin
                stream.push_back({H, DATA_W'($urandom())});
                for (int k = 0; k < int'($urandom_range(0, 6)); k++)
                    stream.push_back({($urandom_range(0, 7) == 0) ? H : B, DATA_W'($urandom())});
                stream.push_back({T, DATA_W'($urandom())});
            end
        end
        idx = 0;
        for (int cyc = 0; cyc < 8000 && idx < stream.size(); cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            {in_flit_id, in_data} = stream[idx];
            grant = ($urandom_range(0, 3) != 0);
            rst = (cyc == 700);
            acc = in_valid && in_ready && !rst;
            tick();
            if (acc) idx++;
        end
        rst = 0;
        in_valid = 0;
        if (idx < stream.size()) timeout_fail("random_stream");
        grant = 1;
        for (int cyc = 0; cyc < 100 && (mq.size() > 0 || req); cyc++) tick();
        if (mq.size() > 0) timeout_fail("random_drain");
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
